franken_mem_arbiter: RTL and testbench
======================================

Name: franken_mem_arbiter

Overview:
Arbitrates the single-ported unified memory between the core's instruction-fetch port and its load/store data port. Sequences each access against a fixed-latency memory and returns read data to the winning port. Generates the `rbusy` stall consumed by the pipeline. Sits between the franken core and the memory model in the top-level.

Parameters:
MEM_LAT, 2, cycles from the mem_re/mem_we cycle to the mem_rdata-valid cycle (legal range 1..15)

Ports:
sig_clk  in  1  clock, all state on posedge
sig_reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  32  fetch address (PC)
if_rdata  out  32  fetched instruction, registered
if_valid  out  1  one-cycle completion pulse for fetch
d_read  in  1  load request, held until d_valid
d_write  in  1  store request, held until d_valid
d_addr  in  32  data address
d_wdata  in  32  store data, already lane-aligned
d_be  in  4  byte enables
d_rdata  out  32  load data, registered
d_valid  out  1  one-cycle completion pulse for data
rbusy  out  1  stall to core
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables
mem_re  out  1  memory read strobe, one cycle
mem_we  out  1  memory write strobe, one cycle
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_re

Behaviour:
- Reset (async, immediate):
  - State IDLE, counter 0, last_grant = FETCH.
  - All outputs 0: if_rdata, d_rdata, valids, mem_*, rbusy (rbusy = 0 only because no request is pending during reset).
- State machine:
  - IDLE -> WAIT on the first posedge with any request.
  - WAIT -> DONE when the counter expires.
  - DONE -> IDLE unconditionally after one cycle.
- Requests are sampled only in IDLE. Requests are ignored in WAIT and DONE.
- Grant in IDLE:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not in last_grant wins (round-robin).
  - Because last_grant resets to FETCH, data wins the first tie after reset.
  - last_grant updates at grant time.
- Data-port conflict: d_write and d_read both high is illegal; treat as write.
- Issue (first WAIT cycle):
  - mem_addr, mem_be, mem_wdata and mem_re or mem_we are registered from the granted port and held for exactly that cycle.
  - Fetch issue: mem_be = 4'b1111, mem_wdata = 0.
  - All mem strobes are 0 outside the issue cycle; mem_addr/mem_be/mem_wdata return to 0 after it.
- Counter (width 4):
  - Loaded with MEM_LAT at the grant edge and decremented each WAIT cycle.
  - At the last WAIT cycle (the mem_rdata-valid cycle, MEM_LAT cycles after issue), mem_rdata is captured into if_rdata or d_rdata.
  - Transition to DONE follows that capture.
- DONE: the granted port's valid pulses high for exactly one cycle.
  - Writes pulse d_valid; d_rdata holds its previous value.
  - The non-granted port's rdata always holds its value.
- rbusy (combinational) = (state == WAIT) | (state == IDLE & (if_req | d_read | d_write)). rbusy is low in DONE.
- Requester protocol: the requester deasserts or changes its request in the cycle after its valid pulse. A request still high in the following IDLE cycle is a new transaction.
- Latency: request cycle 0 -> issue cycle 1 -> data cycle 1+MEM_LAT -> valid cycle 2+MEM_LAT.
  - Total = MEM_LAT+3 cycles per transaction including DONE.
  - No pipelining and no overlap.
- Reset mid-transaction:
  - Aborts immediately; no valid pulse.
  - Late mem_rdata is ignored.
  - last_grant returns to FETCH.

Test Plan:
1. Fetch only, MEM_LAT=2, if_req=1, if_addr=0x00400000 in cycle 0; memory returns 0x00500093 in cycle 3 -> mem_re=1 and mem_addr=0x00400000 in cycle 1 only; if_valid=1 and if_rdata=0x00500093 in cycle 4; rbusy high in cycles 0-3, low in cycle 4.
2. Fresh reset, then if_req and d_read (d_addr=0x10010000) both held from cycle 0 -> data served first (d_valid cycle 4); fetch granted in cycle 5, mem_re cycle 6, if_valid cycle 9.
3. Round-robin with both ports continuously requesting -> grant order D, F, D, F across 4 transactions; valid pulses 5 cycles apart; no valid overlaps.
4. Store: d_write=1, d_addr=0x10010004, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 with those values in cycle 1 only; mem_re stays 0; d_valid in cycle 4; d_rdata unchanged.
5. MEM_LAT=1, single load with data 0x12345678 -> d_valid in cycle 3 with d_rdata=0x12345678; MEM_LAT=5 -> d_valid in cycle 7.
6. Assert sig_reset asynchronously mid-cycle 2 of a fetch -> all outputs 0 immediately; no if_valid; after release, simultaneous requests grant data first.

Source files
------------

// File: rtl/franken_mem_arbiter_if.sv
// Core/memory side bundle for the unified-memory arbiter.
// The arbiter takes the slave view. The core plus memory model take the master view.
interface franken_mem_arbiter_if;
    // Instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    // Load/store data port
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;

    // Pipeline stall
    logic        rbusy;

    // Fixed-latency memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output d_read, d_write, d_addr, d_wdata, d_be,
        input  d_rdata, d_valid,
        input  rbusy,
        input  mem_addr, mem_wdata, mem_be, mem_re, mem_we,
        output mem_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  d_read, d_write, d_addr, d_wdata, d_be,
        output d_rdata, d_valid,
        output rbusy,
        output mem_addr, mem_wdata, mem_be, mem_re, mem_we,
        input  mem_rdata
    );
endinterface

// File: rtl/franken_mem_arbiter.sv
// Round-robin arbiter between fetch and load/store ports onto one
// fixed-latency single-ported memory. Each access runs IDLE -> WAIT -> DONE.
// Accesses are never overlapped. MEM_LAT must be between 1 and 15.
module franken_mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                  sig_clk,
    input  logic                  sig_reset,
    franken_mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    gnt_t               r_last_gnt;
    gnt_t               r_gnt;
    logic               r_gnt_wr;

    logic [31:0]        r_if_rdata;
    logic               r_if_valid;
    logic [31:0]        r_d_rdata;
    logic               r_d_valid;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_be;
    logic               r_mem_re;
    logic               r_mem_we;

    logic               w_d_req;
    logic               w_any_req;
    logic               w_pick_data;
    logic               w_rbusy;

    // A simultaneous read and write on the data port is resolved as a write.
    assign w_d_req     = bus.d_read | bus.d_write;
    assign w_any_req   = bus.if_req | w_d_req;
    // On a tie, the port that did not win last time takes the grant.
    assign w_pick_data = w_d_req & (~bus.if_req | (r_last_gnt == GNT_FETCH));
    assign w_rbusy     = (r_state == ST_WAIT) | ((r_state == ST_IDLE) & w_any_req);

    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.rbusy     = w_rbusy;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_we    = r_mem_we;

    // Access sequencer: grant, one-cycle memory issue, latency countdown, completion pulse.
    always_ff @(posedge sig_clk or posedge sig_reset) begin
        if (sig_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_last_gnt  <= GNT_FETCH;
            r_gnt       <= GNT_FETCH;
            r_gnt_wr    <= 1'b0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_valid   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            // Memory strobes and the bus payload are held for the issue cycle only.
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(MEM_LAT);
                        if (w_pick_data) begin
                            r_gnt       <= GNT_DATA;
                            r_last_gnt  <= GNT_DATA;
                            r_gnt_wr    <= bus.d_write;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_mem_be    <= bus.d_be;
                            r_mem_we    <= bus.d_write;
                            r_mem_re    <= ~bus.d_write;
                        end else begin
                            r_gnt       <= GNT_FETCH;
                            r_last_gnt  <= GNT_FETCH;
                            r_gnt_wr    <= 1'b0;
                            r_mem_addr  <= bus.if_addr;
                            r_mem_wdata <= '0;
                            r_mem_be    <= 4'hF;
                            r_mem_re    <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    // A zero count marks the cycle in which mem_rdata is valid.
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        if (r_gnt == GNT_FETCH) begin
                            r_if_rdata <= bus.mem_rdata;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_d_valid <= 1'b1;
                            if (!r_gnt_wr) begin
                                r_d_rdata <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_franken_mem_arbiter.sv
// Randomized scoreboard bench for franken_mem_arbiter.
// It instantiates three copies, with MEM_LAT = 2, 1 and 5. Each copy has its own
// port drivers, a transaction-level timing and arbitration model, and a memory model.
module tb_franken_mem_arbiter;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int NTX = 30;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of a memory word that has never been written.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C96_0F5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic void chk(input int env, input string name,
                                input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL env%0d %s: got %h expected %h", env, name, act, expv);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_env
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 5;

        logic        rst;
        bit          done = 1'b0;
        int          cyc = 0;
        logic [31:0] nxt_rdata = 32'h0;

        logic [31:0] q_if[$];
        logic [31:0] q_d[$];
        int          pend_c[$];
        logic [31:0] pend_d[$];
        logic [31:0] mem [logic [31:0]];
        logic [31:0] sh  [logic [31:0]];
        logic [31:0] exp_last_d;

        franken_mem_arbiter_if bus();

        franken_mem_arbiter #(.MEM_LAT(LAT)) u_dut (
            .sig_clk   (clk),
            .sig_reset (rst),
            .bus       (bus)
        );

        // Memory read-data driver: presents the scheduled word, otherwise junk.
        initial begin
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
                #1 bus.mem_rdata = nxt_rdata;
            end
        end

        // Monitor: timing/arbitration model, memory model and scoreboard pops.
        int          free_at, exp_sc, ls;
        bit          last_d, was_rst, act_s, req, win_d;
        logic        p_if, p_rd, p_wr;
        logic [31:0] p_ifa, p_da, p_dwd, ea, ewd, mv;
        logic [3:0]  p_be, ebe;
        logic [1:0]  ers, ev;
        bit          exp_rb;

        initial begin
            forever begin
                @(negedge clk);
                if (rst) begin
                    chk(g, "outputs_in_reset",
                        bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata |
                        32'({bus.if_valid, bus.d_valid, bus.mem_be, bus.mem_re,
                             bus.mem_we, bus.rbusy}), 32'h0);
                    last_d  = 1'b0;
                    ls      = -1000;
                    exp_sc  = -1;
                    was_rst = 1'b1;
                    pend_c.delete();
                    pend_d.delete();
                    q_if.delete();
                    q_d.delete();
                    p_if = 1'b0; p_rd = 1'b0; p_wr = 1'b0;
                    nxt_rdata = $urandom;
                end else begin
                    if (was_rst) begin
                        free_at = cyc;
                        was_rst = 1'b0;
                    end
                    req   = bus.if_req | bus.d_read | bus.d_write;
                    act_s = bus.mem_re | bus.mem_we;
                    chk(g, "strobe_cycle", 32'(act_s), 32'(cyc == exp_sc));

                    if (act_s) begin
                        // Winner from the grant cycle's requests
                        if (p_if && (p_rd || p_wr)) win_d = !last_d;
                        else                        win_d = p_rd || p_wr;
                        if (win_d) begin
                            ea = p_da; ebe = p_be; ewd = p_dwd;
                            ers = p_wr ? 2'b01 : 2'b10;
                        end else begin
                            ea = p_ifa; ebe = 4'hF; ewd = 32'h0; ers = 2'b10;
                        end
                        chk(g, "mem_addr",   bus.mem_addr,                   ea);
                        chk(g, "mem_be",     32'(bus.mem_be),                32'(ebe));
                        chk(g, "mem_wdata",  bus.mem_wdata,                  ewd);
                        chk(g, "mem_re_we",  32'({bus.mem_re, bus.mem_we}),  32'(ers));
                        last_d = win_d;
                        ls     = cyc;
                        mv = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : init_val(bus.mem_addr);
                        if (bus.mem_we) begin
                            mem[bus.mem_addr] = merge(mv, bus.mem_wdata, bus.mem_be);
                        end else begin
                            pend_c.push_back(cyc + LAT);
                            pend_d.push_back(mv);
                        end
                    end else begin
                        chk(g, "mem_bus_idle",
                            bus.mem_addr | bus.mem_wdata | 32'(bus.mem_be), 32'h0);
                    end

                    if (cyc >= free_at && req) begin
                        exp_sc  = cyc + 1;
                        free_at = cyc + LAT + 3;
                    end

                    ev = (cyc == ls + LAT + 1) ? (last_d ? 2'b01 : 2'b10) : 2'b00;
                    chk(g, "valid_pulse", 32'({bus.if_valid, bus.d_valid}), 32'(ev));
                    if (bus.if_valid) begin
                        chk(g, "if_outstanding", 32'(q_if.size()), 32'd1);
                        if (q_if.size() > 0) chk(g, "if_rdata", bus.if_rdata, q_if.pop_front());
                    end
                    if (bus.d_valid) begin
                        chk(g, "d_outstanding", 32'(q_d.size()), 32'd1);
                        if (q_d.size() > 0) chk(g, "d_rdata", bus.d_rdata, q_d.pop_front());
                    end

                    if (cyc >= ls && cyc <= ls + LAT) exp_rb = 1'b1;
                    else if (cyc == ls + LAT + 1)     exp_rb = 1'b0;
                    else                              exp_rb = req;
                    chk(g, "rbusy", 32'(bus.rbusy), 32'(exp_rb));

                    nxt_rdata = $urandom;
                    if (pend_c.size() > 0 && pend_c[0] == cyc + 1) begin
                        nxt_rdata = pend_d.pop_front();
                        void'(pend_c.pop_front());
                    end

                    p_if = bus.if_req;  p_rd = bus.d_read;   p_wr = bus.d_write;
                    p_ifa = bus.if_addr; p_da = bus.d_addr;  p_dwd = bus.d_wdata;
                    p_be = bus.d_be;
                end
            end
        end

        // Stimulus: random fetch and load/store streams, then reset-abort scenario.
        logic [31:0] fa, da, dwd, dv, a2;
        logic [3:0]  dbe;
        int          ft, dt, op, k;
        bit          fgot, dgot, fdone, ddone, dropf, dropd;

        initial begin
            rst = 1'b1;
            bus.if_req = 1'b0; bus.if_addr = 32'h0;
            bus.d_read = 1'b0; bus.d_write = 1'b0;
            bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_be = 4'h0;
            exp_last_d = 32'h0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;

            fork
                begin
                    for (int n = 0; n < NTX; n++) begin
                        fa = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 32'd4;
                        bus.if_req = 1'b1;
                        bus.if_addr = fa;
                        q_if.push_back(init_val(fa));
                        fgot = 1'b0; ft = 0;
                        while (!fgot && ft < 200) begin
                            @(negedge clk);
                            fgot = bus.if_valid;
                            ft++;
                        end
                        chk(g, "fetch_completes", 32'(fgot), 32'd1);
                        @(posedge clk);
                        #1 bus.if_req = 1'b0;
                        bus.if_addr = $urandom;
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                begin
                    for (int n = 0; n < NTX; n++) begin
                        op  = $urandom_range(0, 2);
                        da  = 32'h1001_0000 + 32'($urandom_range(0, 15)) * 32'd4;
                        dwd = $urandom;
                        dbe = 4'($urandom);
                        bus.d_addr = da; bus.d_wdata = dwd; bus.d_be = dbe;
                        bus.d_read  = (op != 1);
                        bus.d_write = (op != 0);
                        dv = sh.exists(da) ? sh[da] : init_val(da);
                        if (op == 0) begin
                            exp_last_d = dv;
                            q_d.push_back(dv);
                        end else begin
                            sh[da] = merge(dv, dwd, dbe);
                            q_d.push_back(exp_last_d);
                        end
                        dgot = 1'b0; dt = 0;
                        while (!dgot && dt < 200) begin
                            @(negedge clk);
                            dgot = bus.d_valid;
                            dt++;
                        end
                        chk(g, "data_completes", 32'(dgot), 32'd1);
                        @(posedge clk);
                        #1 bus.d_read = 1'b0;
                        bus.d_write = 1'b0;
                        bus.d_addr = $urandom;
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            join

            // Abort a fetch in its third cycle; nothing may complete.
            a2 = 32'h0040_0100;
            bus.if_req = 1'b1;
            bus.if_addr = a2;
            q_if.push_back(init_val(a2));
            @(posedge clk);
            @(posedge clk);
            #3 rst = 1'b1;
            bus.if_req = 1'b0;
            exp_last_d = 32'h0;
            #1 chk(g, "async_reset_clears",
                   bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata |
                   32'({bus.if_valid, bus.d_valid, bus.mem_be, bus.mem_re,
                        bus.mem_we, bus.rbusy}), 32'h0);
            @(posedge clk);
            @(posedge clk);

            // Simultaneous requests after release: data must win first.
            #1 rst = 1'b0;
            bus.if_req = 1'b1;
            bus.if_addr = a2;
            q_if.push_back(init_val(a2));
            bus.d_read = 1'b1; bus.d_write = 1'b0;
            bus.d_addr = 32'h1001_0000; bus.d_be = 4'hF;
            dv = sh.exists(32'h1001_0000) ? sh[32'h1001_0000] : init_val(32'h1001_0000);
            q_d.push_back(dv);
            fdone = 1'b0; ddone = 1'b0; k = 0;
            while (!(fdone && ddone) && k < 100) begin
                @(negedge clk);
                dropf = bus.if_valid;
                dropd = bus.d_valid;
                @(posedge clk);
                #1;
                if (dropf) begin bus.if_req = 1'b0; fdone = 1'b1; end
                if (dropd) begin bus.d_read = 1'b0; ddone = 1'b1; end
                k++;
            end
            chk(g, "post_reset_pair_completes", 32'({fdone, ddone}), 32'h3);
            repeat (4) @(posedge clk);
            done = 1'b1;
        end
    end

    // Wait for all three environments, then report.
    initial begin
        int t;
        t = 0;
        while (!(g_env[0].done && g_env[1].done && g_env[2].done) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk(-1, "all_envs_done",
            32'({g_env[0].done, g_env[1].done, g_env[2].done}), 32'h7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
